// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner arbitration for a shared 4:1 single-bit mux.
// Registered one-hot grant/select with a bounded grant duration under contention.
module mux4_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] data_in,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       gnt_vld,
    output logic       data_out
);

    localparam int unsigned NREQ   = 4;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned HOLD_W = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0]    sel_q, sel_d;
    logic                vld_q, vld_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;

    logic [NREQ-1:0]     others_c;
    logic [IDX_W-1:0]    win_all_c;
    logic [IDX_W-1:0]    win_oth_c;
    logic                hold_last_c;

    // First set bit of mask scanning upward from start, modulo 4.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] mask,
                                                 input logic [IDX_W-1:0] start);
        logic [IDX_W-1:0] idx;
        rr_pick = start;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = start + IDX_W'(i);
            if (mask[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

    assign others_c    = req & ~(NREQ'(1) << sel_q);
    assign win_all_c   = rr_pick(req, ptr_q);
    assign win_oth_c   = rr_pick(others_c, ptr_q);
    assign hold_last_c = (hold_q == HOLD_W'(MAX_HOLD - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            vld_q   <= 1'b0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            vld_q   <= vld_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        vld_d   = vld_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req != '0) begin
                    state_d = ST_GRANT;
                    gnt_d   = NREQ'(1) << win_all_c;
                    sel_d   = win_all_c;
                    vld_d   = 1'b1;
                    ptr_d   = win_all_c + IDX_W'(1);
                    hold_d  = '0;
                end
            end
            ST_GRANT: begin
                // Holder released or exhausted its quota while others wait: hand over directly.
                if ((!req[sel_q] || hold_last_c) && (others_c != '0)) begin
                    gnt_d  = NREQ'(1) << win_oth_c;
                    sel_d  = win_oth_c;
                    ptr_d  = win_oth_c + IDX_W'(1);
                    hold_d = '0;
                end else if (!req[sel_q]) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    vld_d   = 1'b0;
                    hold_d  = '0;
                end else if (hold_last_c) begin
                    hold_d = '0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign gnt      = gnt_q;
    assign sel      = sel_q;
    assign gnt_vld  = vld_q;
    assign data_out = vld_q & data_in[sel_q];

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios plus randomized
// traffic compared every cycle against a tenure-counting reference model.
module tb_mux4_rr_arbiter;

    localparam int MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] data_in;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       gnt_vld;
    logic       data_out;

    int n_chk  = 0;
    int n_pass = 0;
    bit cmp_en = 1'b0;

    // Reference model: current owner (-1 = none), cycles owned so far, rotation start.
    int m_holder = -1;
    int m_tenure = 0;
    int m_ptr    = 0;
    int m_sel    = 0;

    mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .data_in  (data_in),
        .gnt      (gnt),
        .sel      (sel),
        .gnt_vld  (gnt_vld),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int pick(input logic [3:0] r, input int start, input int excl);
        for (int off = 0; off < 4; off++) begin
            int k;
            k = (start + off) % 4;
            if (r[k] && k != excl) return k;
        end
        return -1;
    endfunction

    function automatic void model_start(input int w);
        m_holder = w;
        m_sel    = w;
        m_ptr    = (w + 1) % 4;
        m_tenure = 1;
    endfunction

    always @(posedge clk) begin
        int w;
        if (!rst_n) begin
            m_holder = -1;
            m_tenure = 0;
            m_ptr    = 0;
            m_sel    = 0;
        end else if (m_holder < 0) begin
            if (req != 4'b0000) model_start(pick(req, m_ptr, -1));
        end else begin
            w = pick(req, m_ptr, m_holder);
            if (!req[m_holder]) begin
                if (w >= 0) model_start(w);
                else m_holder = -1;
            end else if (m_tenure >= MAX_HOLD) begin
                if (w >= 0) model_start(w);
                else m_tenure = 1;
            end else begin
                m_tenure++;
            end
        end
    end

    // Every-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            int exp_gnt;
            int exp_dout;
            exp_gnt  = (m_holder >= 0) ? (1 << m_holder) : 0;
            exp_dout = (m_holder >= 0) ? int'(data_in[m_sel]) : 0;
            chk("model_gnt",  int'(gnt), exp_gnt);
            chk("model_sel",  int'(sel), m_sel);
            chk("model_vld",  int'(gnt_vld), (m_holder >= 0) ? 1 : 0);
            chk("model_dout", int'(data_out), exp_dout);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        req     = 4'b0000;
        data_in = 4'b0000;

        // 1: reset then single request
        step();
        cmp_en = 1'b1;
        step();
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_sel", int'(sel), 0);
        chk("rst_vld", int'(gnt_vld), 0);
        rst_n   = 1'b1;
        req     = 4'b0100;
        data_in = 4'b1010;
        step();
        chk("t1_gnt",  int'(gnt), 4'b0100);
        chk("t1_sel",  int'(sel), 2);
        chk("t1_vld",  int'(gnt_vld), 1);
        chk("t1_dout0", int'(data_out), 0);
        data_in = 4'b1110;
        #1;
        chk("t1_dout1", int'(data_out), 1);

        // 2: round-robin fairness with full contention
        do_reset();
        req = 4'b1111;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (i == 1 || i == 8)  chk("t2_g0", int'(gnt), 4'b0001);
            if (i == 9 || i == 16) chk("t2_g1", int'(gnt), 4'b0010);
            if (i == 17) chk("t2_g2", int'(gnt), 4'b0100);
            if (i == 25) chk("t2_g3", int'(gnt), 4'b1000);
            if (i == 33) chk("t2_g0b", int'(gnt), 4'b0001);
        end

        // 3: early release hands over without a bubble
        do_reset();
        req = 4'b0011;
        step();
        chk("t3_g0", int'(gnt), 4'b0001);
        step();
        step();
        req = 4'b0010;
        step();
        chk("t3_g1",  int'(gnt), 4'b0010);
        chk("t3_vld", int'(gnt_vld), 1);

        // 4: sole holder keeps the grant past MAX_HOLD
        do_reset();
        req = 4'b1000;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t4_sole", int'(gnt), 4'b1000);
        end

        // 5: go idle and resume with wrapped pointer
        do_reset();
        data_in = 4'b1111;
        req     = 4'b0010;
        step();
        chk("t5_g1", int'(gnt), 4'b0010);
        req = 4'b0000;
        step();
        chk("t5_idle_gnt",  int'(gnt), 0);
        chk("t5_idle_vld",  int'(gnt_vld), 0);
        chk("t5_idle_dout", int'(data_out), 0);
        chk("t5_idle_sel",  int'(sel), 1);
        req = 4'b0011;
        step();
        chk("t5_wrap", int'(gnt), 4'b0001);

        // 6: reset mid-grant
        do_reset();
        req = 4'b0100;
        for (int i = 0; i < 6; i++) step();
        chk("t6_pre", int'(gnt), 4'b0100);
        rst_n = 1'b0;
        step();
        chk("t6_rst_gnt", int'(gnt), 0);
        chk("t6_rst_sel", int'(sel), 0);
        chk("t6_rst_vld", int'(gnt_vld), 0);
        rst_n = 1'b1;
        req   = 4'b0110;
        step();
        chk("t6_after", int'(gnt), 4'b0010);

        // Randomized traffic with sticky requests and rare resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            data_in = 4'($urandom_range(0, 15));
            rst_n   = ($urandom_range(0, 199) != 0);
            step();
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
Round-robin arbiter that shares the 4:1 single-bit mux between four requesters. Each requester owns one mux input bit. The block decides who owns the mux, drives the 2-bit select, and limits how long one requester may hold it. It sits directly in front of mux4_1 (sel drives s, data_in drives i) and gates the mux output with a valid flag.

Parameters:
MAX_HOLD, 8, maximum consecutive cycles one grant may last while other requests are pending; legal range 1..255.

Ports:
clk      input   1  rising-edge clock
rst_n    input   1  synchronous active-low reset, sampled on rising clk
req      input   4  request per requester; req[k] high = requester k wants the mux
data_in  input   4  mux data; bit k belongs to requester k
gnt      output  4  one-hot registered grant; all-zero when idle
sel      output  2  registered mux select = index of granted requester
gnt_vld  output  1  registered; high while any grant is active
data_out output  1  combinational; equals data_in[sel] when gnt_vld=1, else 0

Behaviour:
- One clock; reset is synchronous and active-low. All state updates on rising clk.
- Reset (rst_n=0 at a clk edge) sets gnt=0, sel=0, gnt_vld=0, ptr=0 and hold_cnt=0. State goes to IDLE. Reset wins over every other event, including mid-grant.
- Internal state: ptr[1:0] is the highest-priority index for the next decision. hold_cnt is 8 bits.
- Winner selection: scan req starting at ptr, then ptr+1, ptr+2 and ptr+3, all mod 4. The first set bit wins. The scan in GRANT excludes the current holder.
- IDLE:
  - If req==0, stay idle with outputs at reset values.
  - Otherwise go to GRANT on the next edge with gnt=onehot(winner), sel=winner, gnt_vld=1, hold_cnt=0 and ptr=winner+1 mod 4.
  - Latency from req to gnt is exactly 1 cycle.
- GRANT (holder h = sel), evaluated each edge in this priority order:
  1. req[h]=0 and some other req set: switch directly to the new winner on this edge. There is no idle bubble. hold_cnt=0 and ptr=winner+1.
  2. req[h]=0 and no other req: go to IDLE, with gnt=0 and gnt_vld=0. sel keeps its last value and ptr is unchanged.
  3. req[h]=1, hold_cnt==MAX_HOLD-1, and another req set: preempt and switch to the new winner as in rule 1.
  4. req[h]=1, hold_cnt==MAX_HOLD-1, and no other req: keep the grant to h and set hold_cnt=0.
  5. Otherwise keep the grant and increment hold_cnt.
- A grant therefore lasts at most MAX_HOLD cycles while contention exists.
- With MAX_HOLD=1, the grant rotates every cycle under contention.
- gnt is always one-hot or zero. sel always equals the index of the set gnt bit while gnt_vld=1.
- ptr wraps 3->0. A requester that drops and re-raises req gets no priority boost.
- req bits change only between edges and are sampled at edges. Glitches between edges have no effect.
- data_out is purely combinational from sel, gnt_vld and data_in. It adds no latency.

Test Plan:
1. Reset then single request: rst_n=0 for 2 cycles, then req=4'b0100 and data_in=4'b1010. One cycle later gnt=4'b0100, sel=2, gnt_vld=1, data_out=0. With data_in=4'b1110, data_out=1.
2. Round-robin fairness: req=4'b1111 held with MAX_HOLD=8. Grants go 0,1,2,3,0, each lasting exactly 8 cycles with no gap between them.
3. Early release: req=4'b0011, so 0 is granted. Drop req[0] at cycle 3 of the grant. On the next edge gnt=4'b0010, with no cycle of gnt_vld=0.
4. Sole holder past MAX_HOLD: req=4'b1000 held for 20 cycles. gnt stays 4'b1000 continuously, and hold_cnt wraps to 0 at cycle 8 and cycle 16.
5. Go idle and resume: grant to 1, then req=0. Next edge: gnt=0, gnt_vld=0, data_out=0. Then req=4'b0011. The winner is 0, because ptr=2 wraps to 0 before 1.
6. Reset mid-grant: while gnt=4'b0100 and hold_cnt=5, assert rst_n=0 for one edge. Outputs take reset values on that edge. Then req=4'b0110 grants 1, since ptr was reset to 0.
